// File: rtl/priority_decoder_rr.sv
// -----------------------------------------------------------------------------
// priority_decoder_rr
//   N-way priority decoder with a one-deep registered output stage.
//   An accepted request vector is turned into a one-hot grant and a binary
//   index one cycle later. Fixed mode gives the highest set index priority.
//   Round-robin mode starts searching just above the last round-robin winner.
//
// Configuration macro:
//   PRIO_DEC_RR_EN  defined   -> rr_ptr and round-robin search are built and
//                                mode_rr is honoured.
//                   undefined -> fixed priority only; mode_rr is ignored.
//
// Ports:
//   clk           in   1     rising-edge clock
//   rst_n         in   1     asynchronous active-low reset
//   req_i         in   N     request vector, bit k = channel k requesting
//   in_valid      in   1     req_i / mode_rr valid this cycle
//   in_ready      out  1     block can accept (!out_valid || out_ready)
//   mode_rr       in   1     0 = fixed priority, 1 = round-robin
//   grant_onehot  out  N     registered one-hot grant (zero when no request)
//   grant_idx     out  IDXW  registered binary index of the granted bit
//   none          out  1     registered; accepted req_i was all-zero
//   out_valid     out  1     output registers hold an unconsumed result
//   out_ready     in   1     consumer takes the result this cycle
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits for ready, and while valid is high without
// ready the associated data stays stable.
// -----------------------------------------------------------------------------
module priority_decoder_rr #(
   parameter int N = 4,
   localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_i,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            mode_rr,
   output logic [N-1:0]    grant_onehot,
   output logic [IDXW-1:0] grant_idx,
   output logic            none,
   output logic            out_valid,
   input  logic            out_ready
);

   logic            accept;
   logic            any_req;
   logic [IDXW-1:0] fp_idx;
   logic [IDXW-1:0] sel_idx;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign any_req  = |req_i;

   // Fixed priority: ascending scan, later hits overwrite, so the highest
   // set bit ends up selected.
   always_comb begin
      fp_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (req_i[k]) begin
            fp_idx = IDXW'(k);
         end
      end
   end

`ifdef PRIO_DEC_RR_EN
   logic [IDXW-1:0] rr_ptr;
   logic [IDXW-1:0] rr_idx;

   // Round-robin: candidates are rr_ptr+1 .. rr_ptr+N modulo N. Scanning
   // the offsets from far to near and overwriting leaves the nearest hit.
   // The wrap subtracts N explicitly so non-power-of-2 N stays in range.
   always_comb begin
      int p;
      rr_idx = '0;
      p      = 0;
      for (int k = N; k >= 1; k--) begin
         p = int'(rr_ptr) + k;
         if (p >= N) begin
            p = p - N;
         end
         if (req_i[p[IDXW-1:0]]) begin
            rr_idx = p[IDXW-1:0];
         end
      end
   end

   assign sel_idx = mode_rr ? rr_idx : fp_idx;

   // Pointer only moves on a real round-robin grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= IDXW'(N - 1);
      end else if (accept && mode_rr && any_req) begin
         rr_ptr <= rr_idx;
      end
   end
`else
   logic unused_mode_rr;

   assign unused_mode_rr = mode_rr;
   assign sel_idx        = fp_idx;
`endif

   // Output stage: loads on accept, otherwise drains when consumed. Data
   // registers keep stale values after a drain; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         grant_onehot <= '0;
         grant_idx    <= '0;
         none         <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         none         <= !any_req;
         if (any_req) begin
            grant_onehot <= N'(1) << sel_idx;
            grant_idx    <= sel_idx;
         end else begin
            grant_onehot <= '0;
            grant_idx    <= '0;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_priority_decoder_rr.sv
module tb_priority_decoder_rr;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_i = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       mode_rr = 1'b0;
   logic [3:0] grant_onehot;
   logic [1:0] grant_idx;
   logic       none;
   logic       out_valid;
   logic       out_ready = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   priority_decoder_rr #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mode_rr      (mode_rr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .none         (none),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   // Hard time limit so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, want done");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [3:0] req;
      logic       mode;
      logic [1:0] idx_rr;   // expected index with round-robin built
      logic [1:0] idx_fx;   // expected index with fixed priority only
      logic       empty;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_result(input string name, input logic [1:0] idx, input logic empty);
      logic [3:0] exp_oh;
      exp_oh = empty ? 4'b0000 : (4'b0001 << idx);
      check({name, " out_valid"}, 32'(out_valid), 32'd1);
      check({name, " onehot"}, 32'(grant_onehot), 32'(exp_oh));
      check({name, " idx"}, 32'(grant_idx), empty ? 32'd0 : 32'(idx));
      check({name, " none"}, 32'(none), 32'(empty));
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic m, input logic [1:0] irr,
                               input logic [1:0] ifx, input logic e);
      vec_t v;
      v.req = r; v.mode = m; v.idx_rr = irr; v.idx_fx = ifx; v.empty = e;
      return v;
   endfunction

   initial begin
      logic [1:0] exp_idx;

      // rr_ptr starts at 3 after the reset in step 1 and the fixed-mode
      // accepts of steps 2/3 leave it there.
      vecs[0]  = mk(4'b1111, 1'b1, 2'd0, 2'd3, 1'b0);
      vecs[1]  = mk(4'b1111, 1'b1, 2'd1, 2'd3, 1'b0);
      vecs[2]  = mk(4'b1111, 1'b1, 2'd2, 2'd3, 1'b0);
      vecs[3]  = mk(4'b1111, 1'b1, 2'd3, 2'd3, 1'b0);
      vecs[4]  = mk(4'b1111, 1'b1, 2'd0, 2'd3, 1'b0);
      vecs[5]  = mk(4'b0010, 1'b1, 2'd1, 2'd1, 1'b0);  // ptr -> 1
      vecs[6]  = mk(4'b1001, 1'b1, 2'd3, 2'd3, 1'b0);  // skip 2
      vecs[7]  = mk(4'b1001, 1'b1, 2'd0, 2'd3, 1'b0);  // wrap
      vecs[8]  = mk(4'b0000, 1'b1, 2'd0, 2'd0, 1'b1);  // empty, ptr stays 0
      vecs[9]  = mk(4'b1111, 1'b1, 2'd1, 2'd3, 1'b0);
      vecs[10] = mk(4'b0011, 1'b0, 2'd1, 2'd1, 1'b0);  // fixed, ptr stays 1
      vecs[11] = mk(4'b1111, 1'b1, 2'd2, 2'd3, 1'b0);
      vecs[12] = mk(4'b0100, 1'b1, 2'd2, 2'd2, 1'b0);  // full wrap to self
      vecs[13] = mk(4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
      vecs[14] = mk(4'b0001, 1'b1, 2'd0, 2'd0, 1'b0);
      vecs[15] = mk(4'b1100, 1'b1, 2'd2, 2'd3, 1'b0);

      // 1. Reset values, then reset with a pending result.
      #1;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst onehot", 32'(grant_onehot), 32'd0);
      check("rst idx", 32'(grant_idx), 32'd0);
      check("rst none", 32'(none), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; mode_rr = 1'b0; req_i = 4'b0110; out_ready = 1'b0;
      @(posedge clk); #1;
      check("pend out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst onehot", 32'(grant_onehot), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;

      // 2. Fixed priority.
      @(negedge clk);
      in_valid = 1'b1; mode_rr = 1'b0; req_i = 4'b0110; out_ready = 1'b0;
      @(posedge clk); #1;
      check_result("fixed 0110", 2'd2, 1'b0);

      // 3. Backpressure for 3 cycles, then release.
      @(negedge clk);
      req_i = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp onehot held", 32'(grant_onehot), 32'b0100);
         check("bp idx held", 32'(grant_idx), 32'd2);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check_result("bp next", 2'd0, 1'b0);

      // 4-6. Back-to-back table, out_ready held high.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid = 1'b1; req_i = vecs[i].req; mode_rr = vecs[i].mode;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
`ifdef PRIO_DEC_RR_EN
         exp_idx = vecs[i].idx_rr;
`else
         exp_idx = vecs[i].idx_fx;
`endif
         @(posedge clk); #1;
         check_result($sformatf("vec%0d", i), exp_idx, vecs[i].empty);
      end

      // Drain: no new input, consumer ready -> out_valid drops.
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain out_valid", 32'(out_valid), 32'd0);
      check("drain in_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
